// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the two-requester memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_arbiter_if #(
  parameter int unsigned WORD_SIZE = 16
);
  logic                 i_req;
  logic [WORD_SIZE-1:0] i_address;
  logic                 i_ready;
  logic [WORD_SIZE-1:0] i_rdata;
  logic                 d_readM;
  logic                 d_writeM;
  logic [WORD_SIZE-1:0] d_address;
  logic [WORD_SIZE-1:0] d_wdata;
  logic                 d_ready;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 m_readM;
  logic                 m_writeM;
  logic [WORD_SIZE-1:0] m_address;
  logic [WORD_SIZE-1:0] m_wdata;
  logic [WORD_SIZE-1:0] m_rdata;
  logic                 busy;

  modport slave (
    input  i_req, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, m_readM, m_writeM, m_address, m_wdata, busy
  );

  modport master (
    output i_req, i_address, d_readM, d_writeM, d_address, d_wdata, m_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, m_readM, m_writeM, m_address, m_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer: instruction fetch and data access share one
// fixed-latency memory port; one transaction at a time, all outputs registered.
module mem_arbiter #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned LATENCY   = 2
) (
  input logic          clk,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);
  localparam int unsigned      CNT_W    = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t               state_q, state_d;
  logic                 pend_i, pend_d, last_cnt;
  logic                 last_d_q, last_d_d;
  logic                 write_q, write_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 i_ready_q, i_ready_d;
  logic                 d_ready_q, d_ready_d;
  logic                 m_readM_q, m_readM_d;
  logic                 m_writeM_q, m_writeM_d;
  logic                 busy_q, busy_d;
  logic [WORD_SIZE-1:0] m_address_q, m_address_d;
  logic [WORD_SIZE-1:0] m_wdata_q, m_wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;

  assign pend_i   = bus.i_req;
  assign pend_d   = bus.d_readM | bus.d_writeM;
  assign last_cnt = (count_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: under contention the side not granted last time wins
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pend_i && pend_d) state_d = last_d_q ? BUSY_I : BUSY_D;
        else if (pend_i)      state_d = BUSY_I;
        else if (pend_d)      state_d = BUSY_D;
      end
      BUSY_I, BUSY_D: if (last_cnt) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of every registered output and datapath register
  always_comb begin
    last_d_d    = last_d_q;
    write_d     = write_q;
    count_d     = count_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    m_readM_d   = 1'b0;
    m_writeM_d  = 1'b0;
    busy_d      = (state_d != IDLE);
    m_address_d = m_address_q;
    m_wdata_d   = m_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (state_d == BUSY_I) begin
          m_address_d = bus.i_address;
          write_d     = 1'b0;
          last_d_d    = 1'b0;
          count_d     = '0;
          m_readM_d   = 1'b1;
        end else if (state_d == BUSY_D) begin
          // read+write together is treated as a write
          m_address_d = bus.d_address;
          m_wdata_d   = bus.d_wdata;
          write_d     = bus.d_writeM;
          last_d_d    = 1'b1;
          count_d     = '0;
          m_readM_d   = ~bus.d_writeM;
          m_writeM_d  = bus.d_writeM;
        end
      end
      BUSY_I: begin
        if (last_cnt) begin
          i_rdata_d = bus.m_rdata;
          i_ready_d = 1'b1;
        end else begin
          count_d   = count_q + CNT_W'(1);
          m_readM_d = 1'b1;
        end
      end
      BUSY_D: begin
        if (last_cnt) begin
          if (!write_q) d_rdata_d = bus.m_rdata;
          d_ready_d = 1'b1;
        end else begin
          count_d    = count_q + CNT_W'(1);
          m_readM_d  = ~write_q;
          m_writeM_d = write_q;
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_d_q    <= 1'b0;
      write_q     <= 1'b0;
      count_q     <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      m_readM_q   <= 1'b0;
      m_writeM_q  <= 1'b0;
      busy_q      <= 1'b0;
      m_address_q <= '0;
      m_wdata_q   <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      last_d_q    <= last_d_d;
      write_q     <= write_d;
      count_q     <= count_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      m_readM_q   <= m_readM_d;
      m_writeM_q  <= m_writeM_d;
      busy_q      <= busy_d;
      m_address_q <= m_address_d;
      m_wdata_q   <= m_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.i_ready   = i_ready_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.m_readM   = m_readM_q;
  assign bus.m_writeM  = m_writeM_q;
  assign bus.m_address = m_address_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.busy      = busy_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the shared fixed-latency unified memory. Sits between the instruction-fetch side (read-only) and the data-access side (read/write) of the CPU or caches and the single downstream memory port. Grants one transaction at a time, holds the memory request lines for exactly LATENCY cycles, captures read data, and returns a one-cycle ready pulse to the winner. Contention is resolved round-robin, so neither side starves.

## Interface
- WORD_SIZE, 16, address and data width.
- LATENCY, 2, cycles a memory access must be held (integer, ≥1).
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  instruction read request; held until i_ready.
- i_address  in  WORD_SIZE  instruction address.
- i_ready  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  WORD_SIZE  registered instruction read data.
- d_readM  in  1  data read request; held until d_ready.
- d_writeM  in  1  data write request; held until d_ready.
- d_address  in  WORD_SIZE  data address.
- d_wdata  in  WORD_SIZE  data write value.
- d_ready  out  1  one-cycle pulse: data transaction complete (d_rdata valid for reads).
- d_rdata  out  WORD_SIZE  registered data read data.
- m_readM  out  1  memory read strobe.
- m_writeM  out  1  memory write strobe.
- m_address  out  WORD_SIZE  memory address.
- m_wdata  out  WORD_SIZE  memory write data.
- m_rdata  in  WORD_SIZE  memory read data, valid in last held cycle.
- busy  out  1  high in BUSY_I, BUSY_D, DONE.

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE. Reset → IDLE.
- IDLE: pending_i = i_req; pending_d = d_readM | d_writeM. Only i → BUSY_I; only d → BUSY_D; both → side not in last_grant (last_grant resets to I, so first contention goes to D). Neither → stay.
- On grant edge: latch address (and d_wdata, op type) into m_* registers; set last_grant; clear count. Requester-side input changes after grant are ignored.
- d_readM and d_writeM both high: treated as write; d_rdata unchanged.
- BUSY_x: m_readM (or m_writeM for a D write) high, m_address/m_wdata stable. count increments each cycle; at count == LATENCY-1 capture m_rdata into i_rdata/d_rdata (reads only) and → DONE.
- DONE: winner's ready = 1 for this cycle only; m_readM = m_writeM = 0; requests ignored; → IDLE.
- Requester must deassert its request by the edge ending DONE; a request still high in IDLE is a new transaction.
- Count width: clog2(LATENCY)+1 bits; no wrap within a transaction.

## Timing
- Reset (async, any state): state = IDLE, last_grant = I, count = 0, i_ready = d_ready = 0, m_readM = m_writeM = 0, m_address = m_wdata = 0, i_rdata = d_rdata = 0, busy = 0. Reset mid-transaction aborts it; no ready is issued afterwards; memory write may be partial.
- All outputs registered or decoded from state only; no combinational input→output path.
- Request high in cycle 0 (IDLE) → strobes high cycles 1..LATENCY → ready high in cycle LATENCY+1 with rdata valid in the same cycle. LATENCY=2: ready in cycle 3.
- rdata holds until next read completion of the same side.
- Back-to-back: next grant earliest in IDLE cycle LATENCY+2; one transaction per LATENCY+2 cycles; under continuous contention grants alternate D, I, D, I.
- Request arriving during BUSY/DONE waits; it is not lost if held.

## Test plan
- Reset mid-BUSY_D write (d_address=0x10): assert reset_n=0 async → all outputs 0 immediately, no d_ready after release, state IDLE.
- Single I read, LATENCY=2, i_address=0x23, memory returns 0x6000 → m_readM high cycles 1–2, i_ready pulse cycle 3, i_rdata=0x6000, d_ready never high.
- Single D write d_address=0x80, d_wdata=0xBEEF → m_writeM high 2 cycles with m_address=0x80, m_wdata=0xBEEF, d_ready cycle 3; following D read of 0x80 returns 0xBEEF.
- Simultaneous i_req and d_readM held continuously from reset release → grant order D, I, D, I; ready pulses 4 cycles apart, alternating sides.
- D address changed to 0x55 during BUSY_D (latched 0x54) → m_address stays 0x54 until DONE.
- d_readM=d_writeM=1 → write performed, d_rdata unchanged, d_ready once; repeat with LATENCY=1 and LATENCY=3 → ready in cycle 2 and 4 respectively.
